signed_divider_seq: RTL

SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

---
 rtl/signed_divider_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/signed_divider_seq.sv
// -----------------------------------------------------------------------------
// signed_divider_seq
// Sequential 8-bit signed divider using restoring division on magnitudes.
// A request is accepted in IDLE. Eight DIVIDE iterations follow, one per clock,
// and SIGN then applies the signs and presents the result. Dividing by zero
// skips DIVIDE and completes on the next edge with result = {a, 8'hFF}.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request; sampled only in IDLE
//   a            in   8   signed dividend
//   b            in   8   signed divisor
//   busy         out  1   high while a division is in progress
//   done         out  1   one-cycle pulse when result is valid
//   div_by_zero  out  1   registered with result; completed request had b == 0
//   result       out  16  {remainder[7:0], quotient[7:0]}, signed; held
// -----------------------------------------------------------------------------
module signed_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [15:0] result
);

  typedef enum logic [1:0] {IDLE, DIVIDE, SIGN} state_t;

  state_t      state, state_next;

  logic [7:0]  dvd;       // dividend magnitude; quotient bits shift in at the LSB
  logic [7:0]  dvs;       // divisor magnitude
  logic [8:0]  rem;       // partial remainder
  logic [2:0]  cnt;       // iteration index 0..7
  logic        sq;        // quotient sign
  logic        sr;        // remainder sign (sign of dividend)
  logic        zero;      // divisor was zero

  logic        load;
  logic        step;
  logic        finish;

  logic [7:0]  abs_a, abs_b;
  logic [8:0]  shifted;
  logic [9:0]  trial;
  logic [7:0]  q_out, r_mag, r_out;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (b == 8'h00) ? SIGN : DIVIDE;
      DIVIDE:  if (cnt == 3'd7) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    load   = (state == IDLE) && start;
    step   = (state == DIVIDE);
    finish = (state == SIGN);
    busy   = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath combinational helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    // 0x80 maps to 128, which still fits in an 8-bit unsigned magnitude.
    abs_a   = a[7] ? (~a + 8'd1) : a;
    abs_b   = b[7] ? (~b + 8'd1) : b;
    // Shift in the next dividend bit, then trial-subtract the divisor. The
    // extra top bit of trial acts as the borrow / negative flag.
    shifted = {rem[7:0], dvd[7]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    // For a zero divisor the dividend magnitude never shifted, so it serves as
    // the remainder and the sign fix-up reproduces the original a.
    q_out   = zero ? 8'hFF : (sq ? (~dvd + 8'd1) : dvd);
    r_mag   = zero ? dvd : rem[7:0];
    r_out   = sr ? (~r_mag + 8'd1) : r_mag;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop (no memory array), so all of
    // them are cleared by reset to give a fully defined post-reset state.
    if (!rst_n) begin
      dvd         <= 8'h00;
      dvs         <= 8'h00;
      rem         <= 9'h000;
      cnt         <= 3'd0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      zero        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= 16'h0000;
    end else begin
      done <= finish;
      if (load) begin
        dvd  <= abs_a;
        dvs  <= abs_b;
        rem  <= 9'h000;
        cnt  <= 3'd0;
        sq   <= a[7] ^ b[7];
        sr   <= a[7];
        zero <= (b == 8'h00);
      end else if (step) begin
        cnt <= cnt + 3'd1;
        if (!trial[9]) begin
          rem <= trial[8:0];
          dvd <= {dvd[6:0], 1'b1};
        end else begin
          rem <= shifted;
          dvd <= {dvd[6:0], 1'b0};
        end
      end
      if (finish) begin
        result      <= {r_out, q_out};
        div_by_zero <= zero;
      end
    end
  end

endmodule
